// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM state encoding
// and the WIDTH/DIGIT legality check used at elaboration.
package serial_subtractor_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // A configuration is usable when the operand splits into whole digits.
    function automatic bit cfg_legal(input int width, input int digit);
        return (width >= 2) && (digit >= 1) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/response bundle of the digit-serial subtractor.
// The ovf signal exists only when SERIAL_SUBTRACTOR_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             bin;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             valid;
    logic             ack;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             ovf;

    modport master (output start, x, y, bin, ack,
                    input  ready, diff, bout, valid, ovf);
    modport slave  (input  start, x, y, bin, ack,
                    output ready, diff, bout, valid, ovf);
`else
    modport master (output start, x, y, bin, ack,
                    input  ready, diff, bout, valid);
    modport slave  (input  start, x, y, bin, ack,
                    output ready, diff, bout, valid);
`endif
endinterface

// File: rtl/serial_subtractor_fsub_cell.sv
// One-bit full subtractor: d = a - b - c, with borrow out.
module fsub_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic d,
    output logic borrow
);
    assign d      = a ^ b ^ c;
    assign borrow = (~a & b) | (~a & c) | (b & c);
endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: computes x - y - bin over WIDTH/DIGIT cycles,
// DIGIT bits per cycle through a ripple chain of fsub_cell instances.
// Optional signed-overflow output enabled by SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input logic                clock,
    input logic                reset,
    serial_subtractor_if.slave bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = $clog2(N + 1);

    if (!cfg_legal(WIDTH, DIGIT)) begin : g_cfg_err
        $error("serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT >= 1");
    end

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] xs;
    logic [WIDTH-1:0] ys;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             borrow_r;
    logic [DIGIT-1:0] dg;
    logic             cout;

    // Ripple chain over the low DIGIT bits of the operand shift registers;
    // each stage keeps its own carry signal so the chain is not one vector.
    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        logic cin;
        logic bo;
        if (i == 0) begin : g_first
            assign cin = borrow_r;
        end else begin : g_next
            assign cin = g_cell[i-1].bo;
        end
        fsub_cell u_cell (
            .a      (xs[i]),
            .b      (ys[i]),
            .c      (cin),
            .d      (dg[i]),
            .borrow (bo)
        );
    end

    assign cout = g_cell[DIGIT-1].bo;

    // New digit enters at the MSB end; after N digits the LSB digit is at bit 0.
    assign res_next = (res >> DIGIT) | (WIDTH'(dg) << (WIDTH - DIGIT));

    // Control FSM, operand shift registers, result and running borrow.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            xs       <= '0;
            ys       <= '0;
            res      <= '0;
            borrow_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= BUSY;
                        cnt      <= '0;
                        xs       <= bus.x;
                        ys       <= bus.y;
                        borrow_r <= bus.bin;
                    end
                end
                BUSY: begin
                    xs       <= xs >> DIGIT;
                    ys       <= ys >> DIGIT;
                    res      <= res_next;
                    borrow_r <= cout;
                    cnt      <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(N - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready = (state == IDLE);
    assign bus.valid = (state == DONE);
    assign bus.diff  = res;
    assign bus.bout  = borrow_r;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic xmsb;
    logic ymsb;

    // Operand sign bits captured at accept for the overflow flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            xmsb <= 1'b0;
            ymsb <= 1'b0;
        end else if ((state == IDLE) && bus.start) begin
            xmsb <= bus.x[WIDTH-1];
            ymsb <= bus.y[WIDTH-1];
        end
    end

    assign bus.ovf = (xmsb != ymsb) && (res[WIDTH-1] != xmsb);
`endif

endmodule
